sd_spi_responder: RTL and testbench
===================================

Name: sd_spi_responder

Overview:
- SPI-mode SD-card responder: the card-side end of the SD SPI link, i.e. the target that our SD SPI master drives.
- Receives 6-byte SD command frames on MOSI and answers with R1 responses on MISO.
- Serves single-block reads (CMD17) from an external byte memory.
- Used as an in-system SD card model for bring-up and as the bench counterpart for the master.
- Oversamples the SPI pins with sys_clk.

Parameters:
- BLOCK_LEN, 512: data bytes per CMD17 block.
- NCR, 1: 0xFF filler bytes between the last command byte and R1. Must be 1..8.
- ADDR_W, 32: width of rd_addr.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- spi_clk  in  1  SPI clock from the master, mode 0. Frequency must be at most sys_clk/8.
- CS  in  1  chip select, active low.
- MOSI  in  1  serial data from the master.
- MISO  out  1  serial data to the master.
- rd_en  out  1  one-cycle memory read strobe.
- rd_addr  out  ADDR_W  byte address for the read.
- rd_data  in  8  memory data. Valid exactly one sys_clk after rd_en.
- cmd_valid  out  1  one-cycle pulse when a command frame is accepted.
- cmd_idx  out  6  index of the last accepted command.
- cmd_arg  out  32  argument of the last accepted command.
- idle_flag  out  1  card idle state (R1 bit 0).

Behaviour:
- Reset values:
  - MISO=1, rd_en=0, rd_addr=0, cmd_valid=0, cmd_idx=0, cmd_arg=0.
  - idle_flag=1; state=HUNT.
- Pin sampling:
  - spi_clk, CS and MOSI each pass through 2-flop synchronizers.
  - Edge detect runs on the synchronized spi_clk.
  - Rising edge: shift MOSI into rx_sh (MSB first) and increment a 3-bit bit counter.
  - Falling edge: update MISO.
- Byte framing:
  - A byte is complete on the 8th rising edge.
  - On the next falling edge, tx_sh loads the next tx byte and drives its MSB on MISO.
  - On the other falling edges, tx_sh shifts left.
  - The default tx byte is 0xFF.
- States:
  - HUNT: complete bytes are ignored unless rx[7:6]==2'b01. Such a byte starts a frame: cmd_idx_next=rx[5:0], go to ARG.
  - ARG: collect 4 argument bytes MSB first, then the CRC byte. After the 6th byte:
    - Pulse cmd_valid for one cycle and update cmd_idx/cmd_arg.
    - Compute R1, then go to GAP.
  - GAP: transmit NCR bytes of 0xFF, then go to RESP.
  - RESP: transmit R1. If the command is CMD17 and R1==0x00, go to TGAP; otherwise go to HUNT.
  - TGAP: transmit one 0xFF byte, then go to TOKEN.
  - TOKEN: transmit 0xFE, then go to DATA.
  - DATA: transmit BLOCK_LEN bytes, then go to CRC.
  - CRC: transmit 0xFF, 0xFF, then go to HUNT.
- R1 computation:
  - CMD0: R1=0x01 and set idle_flag.
  - CMD1 or CMD41: R1=0x00 and clear idle_flag.
  - CMD17: R1=0x00 if idle_flag=0; otherwise 0x05 (illegal+idle).
  - Any other command: R1=0x04|idle_flag.
- Data fetch:
  - When the TOKEN byte is loaded into tx_sh, assert rd_en with rd_addr=cmd_arg.
  - Latch rd_data into the next-byte register one cycle later.
  - Each time a DATA byte is loaded, issue the next read with rd_addr+1, for the first BLOCK_LEN-1 loads only.
  - rd_addr wraps modulo 2^ADDR_W.
- MOSI bytes received during GAP..CRC are ignored; the host sends 0xFF.
- CS high, at any time including mid-operation:
  - Within 3 sys_clk of the synchronized edge, force MISO=1, clear the bit counter and tx_sh, and go to HUNT.
  - rd_en is not asserted after the abort.
  - idle_flag and cmd_idx/cmd_arg are retained.
  - A partial frame is discarded with no cmd_valid.
- spi_clk edges while CS is high are ignored.
- Asynchronous reset mid-frame returns everything to its reset values immediately.

Optional Feature:
- Macro: SD_CRC_CHECK_EN.
- When defined:
  - CRC7 (poly x^7+x^3+1, init 0) is accumulated over the first 5 frame bytes.
  - If the computed CRC7 differs from crc_byte[7:1], or crc_byte[0]!=1, then R1=0x08|idle_flag.
  - The command is not executed: idle_flag is unchanged and no data phase occurs. cmd_valid still pulses.
- When undefined: the CRC byte is ignored and no CRC logic is generated.

Test Plan:
- Reset, CS low, frame 40 00 00 00 00 95 -> exactly NCR 0xFF bytes, then 0x01; cmd_valid pulses once with cmd_idx=0; idle_flag=1.
- CMD1 frame (41 00 00 00 00 F9) -> R1 0x00 and idle_flag=0. Then CMD17 with arg 0x00000010 -> sequence 0x00, 0xFF, 0xFE, mem[0x10..0x10+BLOCK_LEN-1], 0xFF, 0xFF. rd_addr steps 0x10 upward with exactly BLOCK_LEN rd_en pulses.
- From reset, CMD17 -> R1 0x05, no token follows, rd_en never asserted. Then CMD9 after CMD1 -> R1 0x04.
- CS raised after 100 DATA bytes -> MISO=1 within 3 sys_clk and no further rd_en. Next CMD0 is answered 0x01 normally.
- Leading 0xFF bytes and a spi_clk burst while CS is high are ignored; a frame following them is decoded correctly.
- With SD_CRC_CHECK_EN: CMD0 with CRC byte 0x00 -> R1 0x09; with CRC byte 0x95 -> R1 0x01.

Source files
------------

// File: rtl/sd_spi_responder.sv
// SD-card SPI-mode responder: decodes 6-byte command frames, answers with R1 and serves CMD17 block reads.
// Optional build macro SD_CRC_CHECK_EN validates each frame's CRC7 before the command is executed.
module sd_spi_responder #(
  parameter int unsigned BLOCK_LEN = 512,
  parameter int unsigned NCR       = 1,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              CS,
  input  logic              MOSI,
  output logic              MISO,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              cmd_valid,
  output logic [5:0]        cmd_idx,
  output logic [31:0]       cmd_arg,
  output logic              idle_flag
);

  localparam int unsigned    DCW       = $clog2(BLOCK_LEN + 1);
  localparam logic [DCW-1:0] DATA_LAST = DCW'(BLOCK_LEN - 1);
  localparam logic [2:0]     GAP_LAST  = 3'(NCR - 1);

  typedef enum logic [2:0] {HUNT, ARG, GAP, RESP, TGAP, TOKEN, DATA, CRC} state_t;

  logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic       sclk_prev_q;
  logic       sclk_s, cs_s, mosi_s, rise, fall, byte_done;
  logic [7:0] rx_byte, tx_next;
  logic       crc_ok;

  state_t              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [6:0]          rx_sh_q, rx_sh_d;
  logic [6:0]          tx_sh_q, tx_sh_d;
  logic                miso_q, miso_d;
  logic                load_pend_q, load_pend_d;
  logic [2:0]          frm_cnt_q, frm_cnt_d;
  logic [2:0]          gap_cnt_q, gap_cnt_d;
  logic [DCW-1:0]      data_cnt_q, data_cnt_d;
  logic [5:0]          idx_nxt_q, idx_nxt_d;
  logic [31:0]         arg_sh_q, arg_sh_d;
  logic [7:0]          r1_q, r1_d;
  logic                rd_go_q, rd_go_d;
  logic [7:0]          data_buf_q, data_buf_d;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [5:0]          cmd_idx_q, cmd_idx_d;
  logic [31:0]         cmd_arg_q, cmd_arg_d;
  logic                idle_q, idle_d;

  assign sclk_s    = sclk_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign rise      = ~cs_s & sclk_s & ~sclk_prev_q;
  assign fall      = ~cs_s & ~sclk_s & sclk_prev_q;
  assign byte_done = rise && (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_sh_q, mosi_s};

`ifdef SD_CRC_CHECK_EN
  logic [6:0] crc_q, crc_d;

  function automatic logic [6:0] crc7_upd(input logic [6:0] crc, input logic [7:0] b);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[6] ^ b[7-i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  assign crc_ok = (crc_q == rx_byte[7:1]) && rx_byte[0];
`else
  assign crc_ok = 1'b1;
`endif

  // The state names the byte that goes out on the next byte boundary.
  always_comb begin
    case (state_q)
      RESP:    tx_next = r1_q;
      TOKEN:   tx_next = 8'hFE;
      DATA:    tx_next = data_buf_q;
      default: tx_next = 8'hFF;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    miso_d      = miso_q;
    load_pend_d = load_pend_q;
    frm_cnt_d   = frm_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    data_cnt_d  = data_cnt_q;
    idx_nxt_d   = idx_nxt_q;
    arg_sh_d    = arg_sh_q;
    r1_d        = r1_q;
    rd_go_d     = rd_go_q;
    data_buf_d  = data_buf_q;
    rd_pend_d   = rd_en_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    cmd_valid_d = 1'b0;
    cmd_idx_d   = cmd_idx_q;
    cmd_arg_d   = cmd_arg_q;
    idle_d      = idle_q;
`ifdef SD_CRC_CHECK_EN
    crc_d       = crc_q;
`endif

    if (rd_pend_q) data_buf_d = rd_data;

    if (cs_s) begin
      state_d     = HUNT;
      bit_cnt_d   = '0;
      tx_sh_d     = '0;
      miso_d      = 1'b1;
      load_pend_d = 1'b0;
      rd_pend_d   = 1'b0;
    end else begin
      if (rise) begin
        rx_sh_d   = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end

      if (byte_done) begin
        load_pend_d = 1'b1;
        case (state_q)
          HUNT: begin
            if (rx_byte[7:6] == 2'b01) begin
              idx_nxt_d = rx_byte[5:0];
              frm_cnt_d = '0;
              state_d   = ARG;
`ifdef SD_CRC_CHECK_EN
              crc_d     = crc7_upd(7'h00, rx_byte);
`endif
            end
          end
          ARG: begin
            if (frm_cnt_q != 3'd4) begin
              arg_sh_d  = {arg_sh_q[23:0], rx_byte};
              frm_cnt_d = frm_cnt_q + 3'd1;
`ifdef SD_CRC_CHECK_EN
              crc_d     = crc7_upd(crc_q, rx_byte);
`endif
            end else begin
              cmd_valid_d = 1'b1;
              cmd_idx_d   = idx_nxt_q;
              cmd_arg_d   = arg_sh_q;
              gap_cnt_d   = '0;
              rd_go_d     = 1'b0;
              state_d     = GAP;
              if (!crc_ok) begin
                r1_d = {7'b0000100, idle_q};
              end else begin
                case (idx_nxt_q)
                  6'd0: begin
                    r1_d   = 8'h01;
                    idle_d = 1'b1;
                  end
                  6'd1, 6'd41: begin
                    r1_d   = 8'h00;
                    idle_d = 1'b0;
                  end
                  6'd17: begin
                    r1_d    = idle_q ? 8'h05 : 8'h00;
                    rd_go_d = ~idle_q;
                  end
                  default: r1_d = {7'b0000010, idle_q};
                endcase
              end
            end
          end
          GAP: begin
            if (gap_cnt_q == GAP_LAST) state_d = RESP;
            else gap_cnt_d = gap_cnt_q + 3'd1;
          end
          RESP:  state_d = rd_go_q ? TGAP : HUNT;
          TGAP:  state_d = TOKEN;
          TOKEN: begin
            data_cnt_d = '0;
            state_d    = DATA;
          end
          DATA: begin
            if (data_cnt_q == DATA_LAST) begin
              frm_cnt_d = '0;
              state_d   = CRC;
            end else begin
              data_cnt_d = data_cnt_q + DCW'(1);
            end
          end
          CRC: begin
            if (frm_cnt_q == 3'd1) state_d = HUNT;
            else frm_cnt_d = frm_cnt_q + 3'd1;
          end
          default: state_d = HUNT;
        endcase
      end

      if (fall) begin
        if (load_pend_q) begin
          load_pend_d = 1'b0;
          miso_d      = tx_next[7];
          tx_sh_d     = tx_next[6:0];
          // Each load prefetches the byte after it, so the last data load issues no read.
          if (state_q == TOKEN) begin
            rd_en_d   = 1'b1;
            rd_addr_d = ADDR_W'(cmd_arg_q);
          end else if (state_q == DATA && data_cnt_q != DATA_LAST) begin
            rd_en_d   = 1'b1;
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end else begin
          miso_d  = tx_sh_q[6];
          tx_sh_d = {tx_sh_q[5:0], 1'b1};
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '1;
      sclk_prev_q <= 1'b0;
      state_q     <= HUNT;
      bit_cnt_q   <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '1;
      miso_q      <= 1'b1;
      load_pend_q <= 1'b0;
      frm_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      data_cnt_q  <= '0;
      idx_nxt_q   <= '0;
      arg_sh_q    <= '0;
      r1_q        <= 8'hFF;
      rd_go_q     <= 1'b0;
      data_buf_q  <= '0;
      rd_pend_q   <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_idx_q   <= '0;
      cmd_arg_q   <= '0;
      idle_q      <= 1'b1;
`ifdef SD_CRC_CHECK_EN
      crc_q       <= '0;
`endif
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi_clk};
      cs_sync_q   <= {cs_sync_q[0], CS};
      mosi_sync_q <= {mosi_sync_q[0], MOSI};
      sclk_prev_q <= sclk_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      miso_q      <= miso_d;
      load_pend_q <= load_pend_d;
      frm_cnt_q   <= frm_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      data_cnt_q  <= data_cnt_d;
      idx_nxt_q   <= idx_nxt_d;
      arg_sh_q    <= arg_sh_d;
      r1_q        <= r1_d;
      rd_go_q     <= rd_go_d;
      data_buf_q  <= data_buf_d;
      rd_pend_q   <= rd_pend_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_idx_q   <= cmd_idx_d;
      cmd_arg_q   <= cmd_arg_d;
      idle_q      <= idle_d;
`ifdef SD_CRC_CHECK_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign MISO      = miso_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_idx   = cmd_idx_q;
  assign cmd_arg   = cmd_arg_q;
  assign idle_flag = idle_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: command table, CMD17 block read, CS abort, async reset.
`timescale 1ns/1ps
module tb_sd_spi_responder;

  localparam int unsigned BLEN = 128;
  localparam int unsigned NCRP = 2;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        spi_clk = 1'b0;
  logic        cs      = 1'b1;
  logic        mosi    = 1'b1;
  logic        miso, rd_en, cmd_valid, idle_flag;
  logic [31:0] rd_addr, cmd_arg;
  logic [5:0]  cmd_idx;
  logic [7:0]  rd_data = 8'h00;

  int checks   = 0;
  int failures = 0;
  int cv_cnt   = 0;
  int rd_cnt   = 0;
  logic [31:0] rd_log[$];

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [7:0]  r1;
    logic        idle;
  } vec_t;
  vec_t tbl[8];

  sd_spi_responder #(.BLOCK_LEN(BLEN), .NCR(NCRP), .ADDR_W(32)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .spi_clk(spi_clk), .CS(cs), .MOSI(mosi),
    .MISO(miso), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .cmd_valid(cmd_valid), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .idle_flag(idle_flag)
  );

  always #10 sys_clk = ~sys_clk;

  function automatic logic [7:0] mem_b(input logic [31:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge sys_clk) rd_data <= rd_en ? mem_b(rd_addr) : 8'h00;

  always @(negedge sys_clk) begin
    if (cmd_valid) cv_cnt++;
    if (rd_en) begin
      rd_cnt++;
      rd_log.push_back(rd_addr);
    end
  end

  function automatic logic [7:0] crc_byte(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    logic [6:0]  c;
    logic        fb;
    m = {2'b01, idx, arg};
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ m[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return {c, 1'b1};
  endfunction

  function automatic int addr_mism(input logic [31:0] base, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= rd_log.size()) bad++;
      else if (rd_log[i] !== base + 32'(i)) bad++;
    end
    return bad;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #120;
      rx[i] = miso;
      spi_clk = 1'b1;
      #120;
      spi_clk = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crcb);
    logic [7:0] b;
    xfer({2'b01, idx}, b);
    xfer(arg[31:24], b);
    xfer(arg[23:16], b);
    xfer(arg[15:8], b);
    xfer(arg[7:0], b);
    xfer(crcb, b);
  endtask

  task automatic get_r1(input string name, input logic [7:0] exp);
    logic [7:0] b;
    for (int k = 0; k < int'(NCRP); k++) begin
      xfer(8'hFF, b);
      chk({name, " ncr"}, b, 8'hFF);
    end
    xfer(8'hFF, b);
    chk({name, " r1"}, b, exp);
  endtask

  initial begin
    logic [7:0] b;
    int cv0, rd0, n;

    tbl[0] = '{6'd0,  32'h0000_0000, 8'h01, 1'b1};
    tbl[1] = '{6'd17, 32'h0000_0010, 8'h05, 1'b1};
    tbl[2] = '{6'd8,  32'h0000_01AA, 8'h05, 1'b1};
    tbl[3] = '{6'd1,  32'h0000_0000, 8'h00, 1'b0};
    tbl[4] = '{6'd9,  32'hA5A5_0000, 8'h04, 1'b0};
    tbl[5] = '{6'd41, 32'h4000_0000, 8'h00, 1'b0};
    tbl[6] = '{6'd0,  32'h0000_0000, 8'h01, 1'b1};
    tbl[7] = '{6'd41, 32'h0000_0000, 8'h00, 1'b0};

    repeat (5) @(negedge sys_clk);
    #2;
    rst_n = 1'b1;
    #40;
    chk("reset miso", miso, 1);
    chk("reset rd_en", rd_en, 0);
    chk("reset rd_addr", rd_addr, 0);
    chk("reset cmd_valid", cmd_valid, 0);
    chk("reset cmd_idx", cmd_idx, 0);
    chk("reset cmd_arg", cmd_arg, 0);
    chk("reset idle", idle_flag, 1);

    cs = 1'b0;
    #120;

`ifdef SD_CRC_CHECK_EN
    cv0 = cv_cnt;
    send_cmd(6'd0, 32'h0, 8'h00);
    get_r1("crc bad", 8'h09);
    chk("crc bad cmd_valid", cv_cnt - cv0, 1);
    send_cmd(6'd0, 32'h0, 8'h95);
    get_r1("crc good", 8'h01);
`endif

    for (int v = 0; v < 8; v++) begin
      cv0 = cv_cnt;
      rd0 = rd_cnt;
      send_cmd(tbl[v].idx, tbl[v].arg, crc_byte(tbl[v].idx, tbl[v].arg));
      get_r1($sformatf("vec%0d", v), tbl[v].r1);
      xfer(8'hFF, b);
      chk($sformatf("vec%0d tail0", v), b, 8'hFF);
      xfer(8'hFF, b);
      chk($sformatf("vec%0d tail1", v), b, 8'hFF);
      chk($sformatf("vec%0d cmd_valid", v), cv_cnt - cv0, 1);
      chk($sformatf("vec%0d cmd_idx", v), cmd_idx, tbl[v].idx);
      chk($sformatf("vec%0d cmd_arg", v), cmd_arg, tbl[v].arg);
      chk($sformatf("vec%0d idle", v), idle_flag, tbl[v].idle);
      chk($sformatf("vec%0d rd_en", v), rd_cnt - rd0, 0);
    end

    // Full CMD17 block read
    rd_log.delete();
    rd0 = rd_cnt;
    send_cmd(6'd17, 32'h10, crc_byte(6'd17, 32'h10));
    get_r1("rd", 8'h00);
    xfer(8'hFF, b);
    chk("rd tgap", b, 8'hFF);
    xfer(8'hFF, b);
    chk("rd token", b, 8'hFE);
    for (int i = 0; i < int'(BLEN); i++) begin
      xfer(8'hFF, b);
      chk($sformatf("rd data%0d", i), b, mem_b(32'h10 + 32'(i)));
    end
    xfer(8'hFF, b);
    chk("rd crc0", b, 8'hFF);
    xfer(8'hFF, b);
    chk("rd crc1", b, 8'hFF);
    xfer(8'hFF, b);
    chk("rd after", b, 8'hFF);
    chk("rd rd_en count", rd_cnt - rd0, BLEN);
    chk("rd addr seq", addr_mism(32'h10, int'(BLEN)), 0);

    // CMD17 near the top of the address space, aborted by CS after 100 data bytes
    rd_log.delete();
    rd0 = rd_cnt;
    cv0 = cv_cnt;
    send_cmd(6'd17, 32'hFFFF_FFC0, crc_byte(6'd17, 32'hFFFF_FFC0));
    get_r1("ab", 8'h00);
    xfer(8'hFF, b);
    chk("ab tgap", b, 8'hFF);
    xfer(8'hFF, b);
    chk("ab token", b, 8'hFE);
    for (int i = 0; i < 100; i++) begin
      xfer(8'hFF, b);
      chk($sformatf("ab data%0d", i), b, mem_b(32'hFFFF_FFC0 + 32'(i)));
    end
    #120;
    chk("ab miso before cs", miso, 0);
    cs = 1'b1;
    n = 0;
    while (miso !== 1'b1 && n < 8) begin
      @(negedge sys_clk);
      n++;
    end
    #2;
    chk("ab miso forced", miso, 1);
    chk("ab miso late", n > 5, 0);
    xfer(8'h40, b);
    xfer(8'h00, b);
    chk("ab rd_en count", rd_cnt - rd0, 102);
    chk("ab addr seq wrap", addr_mism(32'hFFFF_FFC0, 102), 0);
    chk("ab cmd_valid", cv_cnt - cv0, 1);
    chk("ab cmd_idx kept", cmd_idx, 17);
    chk("ab cmd_arg kept", cmd_arg, 32'hFFFF_FFC0);
    chk("ab idle kept", idle_flag, 0);

    // Leading filler bytes, then CMD0
    cv0 = cv_cnt;
    cs = 1'b0;
    #120;
    xfer(8'hFF, b);
    xfer(8'hFF, b);
    send_cmd(6'd0, 32'h0, 8'h95);
    get_r1("post", 8'h01);
    chk("post idle", idle_flag, 1);
    chk("post cmd_idx", cmd_idx, 0);
    chk("post cmd_valid", cv_cnt - cv0, 1);

    // Partial frame discarded by CS, then a full CMD1
    cv0 = cv_cnt;
    xfer(8'h41, b);
    xfer(8'h12, b);
    xfer(8'h34, b);
    cs = 1'b1;
    #240;
    cs = 1'b0;
    #120;
    chk("part no cmd_valid", cv_cnt - cv0, 0);
    send_cmd(6'd1, 32'h1234_5678, crc_byte(6'd1, 32'h1234_5678));
    get_r1("part cmd1", 8'h00);
    chk("part cmd_valid", cv_cnt - cv0, 1);
    chk("part cmd_arg", cmd_arg, 32'h1234_5678);
    chk("part idle", idle_flag, 0);

    // Asynchronous reset in the middle of a frame
    xfer(8'h49, b);
    xfer(8'h00, b);
    rst_n = 1'b0;
    #1;
    chk("arst miso", miso, 1);
    chk("arst rd_en", rd_en, 0);
    chk("arst rd_addr", rd_addr, 0);
    chk("arst cmd_valid", cmd_valid, 0);
    chk("arst cmd_idx", cmd_idx, 0);
    chk("arst cmd_arg", cmd_arg, 0);
    chk("arst idle", idle_flag, 1);
    #100;
    rst_n = 1'b1;
    #100;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
